// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare branch prediction unit.
package bp_pkg;

  localparam int unsigned XLEN  = 32;
  // Tag field is sized for the smallest possible index so any depth fits.
  localparam int unsigned TAG_W = XLEN - 2;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam logic [1:0] PHT_RESET = WNT;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic             is_jump;
  } btb_entry_t;

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer: async read, sync write, async clear.
module bpu_btb
  import bp_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  btb_entry_t entry_q [NUM_ENTRIES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= '0;
    end else if (wr_en) begin
      entry_q[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry = entry_q[rd_idx];

endmodule

// File: rtl/gshare_bpu.sv
// Gshare predictor: combinational IF lookup, MEM resolve, clocked PHT/GHR/BTB update.
module gshare_bpu
  import bp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_ENTRIES = 256,
  parameter int unsigned GHR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic                  if_branch_predict,
  output logic [DATA_WIDTH-1:0] if_pc_predict,
  input  logic [DATA_WIDTH-1:0] mem_PC,
  input  logic [DATA_WIDTH-1:0] mem_pc_plus_4,
  input  logic [DATA_WIDTH-1:0] mem_pc_target,
  input  logic                  mem_branch,
  input  logic                  mem_taken,
  input  logic [1:0]            mem_jump,
  input  logic [DATA_WIDTH-1:0] mem_pc_predict,
  input  logic                  mem_branch_predict,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  logic [GHR_WIDTH-1:0] ghr_q;
  logic [GHR_WIDTH:0]   ghr_shift;
  logic [1:0]           pht_q [NUM_ENTRIES];
  logic [31:0]          branch_count_q, mispredict_count_q;

  logic [IDX_W-1:0]      if_idx, if_pht_idx, mem_idx, mem_pht_idx;
  logic [DATA_WIDTH-1:0] if_tag_full, mem_tag_full, actual_next;
  logic [TAG_W-1:0]      if_tag, mem_tag;
  btb_entry_t            rd_entry, wr_entry;
  logic                  btb_hit, redirect_taken, btb_wr;

  // Lookup
  assign if_idx      = if_pc[IDX_W+1:2];
  assign if_tag_full = if_pc >> (IDX_W + 2);
  assign if_tag      = TAG_W'(if_tag_full);
  assign if_pht_idx  = if_idx ^ IDX_W'(ghr_q);

  assign btb_hit           = ~reset & rd_entry.valid & (rd_entry.tag == if_tag);
  assign if_branch_predict = btb_hit & (rd_entry.is_jump | pht_q[if_pht_idx][1]);
  assign if_pc_predict     = if_branch_predict ? rd_entry.target : if_pc + DATA_WIDTH'(4);

  // Resolve
  assign redirect_taken = (mem_branch & mem_taken) | (mem_jump != JUMP_NONE);
  assign actual_next    = redirect_taken ? mem_pc_target : mem_pc_plus_4;
  assign redirect_pc    = actual_next;
  assign mispredict     = ~reset & (mem_pc_predict != actual_next);

  // Update
  assign mem_idx      = mem_PC[IDX_W+1:2];
  assign mem_tag_full = mem_PC >> (IDX_W + 2);
  assign mem_tag      = TAG_W'(mem_tag_full);
  assign mem_pht_idx  = mem_idx ^ IDX_W'(ghr_q);
  assign ghr_shift    = {ghr_q, mem_taken};

  assign btb_wr   = redirect_taken;
  assign wr_entry = '{valid: 1'b1, tag: mem_tag, target: mem_pc_target,
                      is_jump: (mem_jump != JUMP_NONE)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q              <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) pht_q[i] <= PHT_RESET;
    end else begin
      if (mem_branch) begin
        if (mem_taken && pht_q[mem_pht_idx] != ST) begin
          pht_q[mem_pht_idx] <= pht_q[mem_pht_idx] + 2'd1;
        end else if (!mem_taken && pht_q[mem_pht_idx] != SNT) begin
          pht_q[mem_pht_idx] <= pht_q[mem_pht_idx] - 2'd1;
        end
        ghr_q <= ghr_shift[GHR_WIDTH-1:0];
      end
      if (mem_branch || mem_jump != JUMP_NONE) branch_count_q <= branch_count_q + 32'd1;
      if (mispredict) mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

  bpu_btb #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_btb (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (if_idx),
    .rd_entry (rd_entry),
    .wr_en    (btb_wr),
    .wr_idx   (mem_idx),
    .wr_entry (wr_entry)
  );

  // Fetch-time taken bit is carried down the pipe but resolution only needs the PC.
  logic unused_ok;
  assign unused_ok = mem_branch_predict;

endmodule

// File: tb/tb_gshare_bpu.sv
// Scoreboard bench for gshare_bpu against a table-based reference model.
module tb_gshare_bpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_branch_predict;
  logic [31:0] if_pc_predict;
  logic [31:0] mem_PC, mem_pc_plus_4, mem_pc_target, mem_pc_predict;
  logic        mem_branch, mem_taken, mem_branch_predict;
  logic [1:0]  mem_jump;
  logic        mispredict;
  logic [31:0] redirect_pc, branch_count, mispredict_count;

  always #5 clk = ~clk;

  gshare_bpu dut (
    .clk                (clk),
    .reset              (reset),
    .if_pc              (if_pc),
    .if_branch_predict  (if_branch_predict),
    .if_pc_predict      (if_pc_predict),
    .mem_PC             (mem_PC),
    .mem_pc_plus_4      (mem_pc_plus_4),
    .mem_pc_target      (mem_pc_target),
    .mem_branch         (mem_branch),
    .mem_taken          (mem_taken),
    .mem_jump           (mem_jump),
    .mem_pc_predict     (mem_pc_predict),
    .mem_branch_predict (mem_branch_predict),
    .mispredict         (mispredict),
    .redirect_pc        (redirect_pc),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count)
  );

  typedef struct {
    int          cyc;
    logic        pred;
    logic [31:0] ppc;
    logic        misp;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: plain tables indexed by PC word address.
  int          m_pht [256];
  bit          m_v   [256];
  logic [31:0] m_tag [256];
  logic [31:0] m_tgt [256];
  bit          m_j   [256];
  int          m_ghr;
  logic [31:0] m_bc, m_mc;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) begin
      m_pht[i] = 1; m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_j[i] = 0;
    end
    m_ghr = 0; m_bc = 0; m_mc = 0;
  endfunction

  function automatic int widx(input logic [31:0] pc);
    return int'((pc / 4) % 256);
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, output logic taken);
    int i;
    i = widx(pc);
    taken = m_v[i] && (m_tag[i] == pc / 1024) && (m_j[i] || m_pht[i ^ m_ghr] >= 2);
    return taken ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void chk(input string name, input int c, input logic [31:0] got,
                              input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, c, got, want);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("if_branch_predict", e.cyc, {31'd0, if_branch_predict}, {31'd0, e.pred});
      chk("if_pc_predict", e.cyc, if_pc_predict, e.ppc);
      chk("mispredict", e.cyc, {31'd0, mispredict}, {31'd0, e.misp});
      chk("redirect_pc", e.cyc, redirect_pc, e.rpc);
      chk("branch_count", e.cyc, branch_count, e.bc);
      chk("mispredict_count", e.cyc, mispredict_count, e.mc);
    end
  end

  // Drive one cycle of inputs, record the expected response, then advance the model.
  task automatic step(input bit rst, input logic [31:0] ipc, input bit bubble, input bit br,
                      input bit tk, input logic [1:0] jp, input logic [31:0] mpc,
                      input logic [31:0] tgt, input logic [31:0] ppred);
    exp_t        e;
    logic        t;
    logic [31:0] pc4, actual;
    bit          redir;
    int          pi, wi;
    pc4 = bubble ? 32'd0 : mpc + 32'd4;
    reset              = rst;
    if_pc              = ipc;
    mem_PC             = bubble ? 32'd0 : mpc;
    mem_pc_plus_4      = pc4;
    mem_pc_target      = bubble ? 32'd0 : tgt;
    mem_branch         = bubble ? 1'b0 : br;
    mem_taken          = bubble ? 1'b0 : tk;
    mem_jump           = bubble ? 2'b00 : jp;
    mem_pc_predict     = bubble ? 32'd0 : ppred;
    mem_branch_predict = 1'b0;
    if (rst) model_reset();
    e.cyc = cyc;
    e.ppc = model_next(ipc, t);
    e.pred = t;
    redir = (mem_branch && mem_taken) || (mem_jump != 2'b00);
    actual = redir ? mem_pc_target : mem_pc_plus_4;
    e.rpc = actual;
    e.misp = !rst && (mem_pc_predict != actual);
    e.bc = m_bc;
    e.mc = m_mc;
    exp_q.push_back(e);
    if (!rst) begin
      wi = widx(mem_PC);
      if (mem_branch) begin
        pi = wi ^ m_ghr;
        if (mem_taken) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
        else           m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
        m_ghr = ((m_ghr * 2) + int'(mem_taken)) % 256;
      end
      if (redir) begin
        m_v[wi] = 1; m_tag[wi] = mem_PC / 1024; m_tgt[wi] = mem_pc_target;
        m_j[wi] = (mem_jump != 2'b00);
      end
      if (mem_branch || mem_jump != 2'b00) m_bc = m_bc + 1;
      if (e.misp) m_mc = m_mc + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [31:0] pool [8];

  initial begin
    logic [31:0] ipc, mpc, tgt, pp;
    logic        t;
    bit          br, tk;
    logic [1:0]  jp;
    int          sel;

    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'h500;
    pool[4] = 32'h100 + 32'h400; pool[5] = 32'h3fc; pool[6] = 32'h1000_0040;
    pool[7] = 32'h80;

    reset = 1'b1; if_pc = 0; mem_PC = 0; mem_pc_plus_4 = 0; mem_pc_target = 0;
    mem_branch = 0; mem_taken = 0; mem_jump = 0; mem_pc_predict = 0; mem_branch_predict = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Directed: idle lookup, taken branch mispredict, repeat taken, JAL, saturation.
    step(0, 32'h100, 1, 0, 0, 2'b00, 0, 0, 0);
    step(0, 32'h100, 0, 1, 1, 2'b00, 32'h100, 32'h80, 32'h104);
    step(0, 32'h100, 0, 1, 1, 2'b00, 32'h100, 32'h80, 32'h80);
    step(0, 32'h100, 1, 0, 0, 2'b00, 0, 0, 0);
    step(0, 32'h200, 0, 0, 0, 2'b01, 32'h200, 32'h300, 32'h204);
    step(0, 32'h200, 1, 0, 0, 2'b00, 0, 0, 0);
    repeat (5) step(0, 32'h500, 0, 1, 0, 2'b00, 32'h500, 32'h600, 32'h504);
    step(0, 32'h100, 0, 1, 1, 2'b00, 32'h104, 32'h40, 32'h40);
    // Reset in the middle of a mispredicting MEM instruction.
    step(1, 32'h200, 0, 1, 1, 2'b00, 32'h100, 32'h80, 32'h104);
    step(0, 32'h200, 1, 0, 0, 2'b00, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      ipc = pool[$urandom_range(7)];
      mpc = pool[$urandom_range(7)];
      tgt = {$urandom_range(32'h3ff), 2'b00};
      if ($urandom_range(3) == 0) tgt = pool[$urandom_range(7)];
      sel = $urandom_range(9);
      br = (sel < 6); tk = $urandom_range(1) == 1;
      jp = (sel == 6) ? 2'b01 : (sel == 7) ? 2'b10 : 2'b00;
      case ($urandom_range(3))
        0: pp = model_next(mpc, t);
        1: pp = mpc + 32'd4;
        2: pp = tgt;
        default: pp = $urandom;
      endcase
      step($urandom_range(99) == 0, ipc, sel == 9, br, tk, jp, mpc, tgt, pp);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
